supplier: RTL and testbench

Restocking side of the vending machine stock path: owns the seven per-lane stock registers that the purchase side reads as its pre-sale counts, and writes them from an operator restock sequence. Merges completed sales, which decrement stock, with operator restock commands, which increment it, under saturating 3-bit arithmetic. It reports, for a hold window, how many items each command actually accepted. Sits between the operator switch/button inputs and the purchase/payment logic.

---
 rtl/supplier.sv | 185 ++++++++++++++++++
 tb/tb_supplier.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/supplier.sv
// Restock side of the vending stock path: per-lane stock registers,
// operator restock FSM and same-cycle merge with completed sales.
module supplier #(
  parameter logic [2:0] INIT_COUNT  = 3'd0,
  parameter int         HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ens,
  input  logic [2:0] num,
  input  logic [6:0] addcount,
  input  logic       confirm,
  input  logic       sale_valid,
  input  logic [2:0] sale_num,
  input  logic [2:0] sale_count,
  output logic [2:0] count1,
  output logic [2:0] count2,
  output logic [2:0] count3,
  output logic [2:0] count4,
  output logic [2:0] count5,
  output logic [2:0] count6,
  output logic [2:0] count7,
  output logic [2:0] accepted,
  output logic       overflow,
  output logic       busy,
  output logic       done,
  output logic       sale_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT,
    HOLD
  } state_e;

  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0] lnum_q, lnum_d;
  logic [2:0] lq_q, lq_d;
  logic conf_q, conf_prev_q;
  logic [2:0] cnt_q [1:7];
  logic [2:0] cnt_d [1:7];
  logic [2:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [2:0] q;
  logic rise;
  logic commit;
  logic sale_ok;
  logic [2:0] t [1:7];
  logic [3:0] s;

  assign rise = conf_q & ~conf_prev_q;

  // Non-one-hot quantity selections fall back to a single item
  always_comb begin
    q = 3'd1;
    if ($onehot(addcount)) begin
      for (int i = 0; i < 7; i++) begin
        if (addcount[i]) q = 3'(7 - i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lnum_d  = lnum_q;
    lq_d    = lq_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ens) state_d = ARMED;
      end
      ARMED: begin
        if (!ens) begin
          state_d = IDLE;
        end else if (rise) begin
          lnum_d  = num;
          lq_d    = q;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        hold_d  = HW'(HOLD_CYCLES - 1);
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = ens ? ARMED : IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sale lands first; a same-lane restock then saturates on the result
  always_comb begin
    sale_ok = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    s       = '0;
    for (int i = 1; i <= 7; i++) begin
      t[i] = cnt_q[i];
      if (sale_valid && sale_num == 3'(i) &&
          sale_count <= cnt_q[i]) begin
        sale_ok = 1'b1;
        t[i]    = cnt_q[i] - sale_count;
      end
      cnt_d[i] = t[i];
    end
    if (commit) begin
      if (lnum_q == 3'd0) begin
        acc_d = 3'd0;
        ovf_d = 1'b1;
      end else begin
        for (int i = 1; i <= 7; i++) begin
          if (lnum_q == 3'(i)) begin
            s = {1'b0, t[i]} + {1'b0, lq_q};
            if (s > 4'd7) begin
              cnt_d[i] = 3'd7;
              acc_d    = 3'd7 - t[i];
              ovf_d    = 1'b1;
            end else begin
              cnt_d[i] = s[2:0];
              acc_d    = lq_q;
              ovf_d    = 1'b0;
            end
          end
        end
      end
    end
    err_d  = sale_valid & ~sale_ok;
    done_d = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      lnum_q      <= '0;
      lq_q        <= '0;
      conf_q      <= 1'b0;
      conf_prev_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 1; i <= 7; i++) cnt_q[i] <= INIT_COUNT;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      lnum_q      <= lnum_d;
      lq_q        <= lq_d;
      conf_q      <= confirm;
      conf_prev_q <= conf_q;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      err_q       <= err_d;
      for (int i = 1; i <= 7; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign count1   = cnt_q[1];
  assign count2   = cnt_q[2];
  assign count3   = cnt_q[3];
  assign count4   = cnt_q[4];
  assign count5   = cnt_q[5];
  assign count6   = cnt_q[6];
  assign count7   = cnt_q[7];
  assign accepted = acc_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == COMMIT) || (state_q == HOLD);
  assign done     = done_q;
  assign sale_err = err_q;

endmodule

// File: tb/tb_supplier.sv
// Directed bench for supplier: restock commits, sales, merges,
// confirm edge handling, lane 0 and async reset mid-hold.
module tb_supplier;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ens = 1'b0;
  logic [2:0] num = '0;
  logic [6:0] addcount = '0;
  logic       confirm = 1'b0;
  logic       sale_valid = 1'b0;
  logic [2:0] sale_num = '0;
  logic [2:0] sale_count = '0;
  logic [2:0] count1, count2, count3, count4, count5, count6, count7;
  logic [2:0] accepted;
  logic       overflow, busy, done, sale_err;

  int checks = 0;
  int failures = 0;
  int bc, dc;
  logic got_done;
  logic [20:0] snap;

  supplier #(.INIT_COUNT(3'd0), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .ens(ens), .num(num),
    .addcount(addcount), .confirm(confirm),
    .sale_valid(sale_valid), .sale_num(sale_num),
    .sale_count(sale_count),
    .count1(count1), .count2(count2), .count3(count3),
    .count4(count4), .count5(count5), .count6(count6),
    .count7(count7), .accepted(accepted), .overflow(overflow),
    .busy(busy), .done(done), .sale_err(sale_err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] all_counts();
    return {count7, count6, count5, count4, count3, count2, count1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes ARMED with confirm low; optional sale rides the COMMIT cycle
  task automatic commit(input logic [2:0] n, input logic [6:0] ac,
                        input logic sv, input logic [2:0] sn,
                        input logic [2:0] sc);
    int k;
    num = n;
    addcount = ac;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
    sale_valid = sv;
    sale_num = sn;
    sale_count = sc;
    tick();
    got_done = done;
    sale_valid = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_counts", 32'(all_counts()), 32'd0);
    check("rst_acc", 32'(accepted), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(sale_err), 32'd0);

    // Lane 3 restock q=3 with exact timing
    ens = 1'b1;
    num = 3'd3;
    addcount = 7'b0010000;
    tick();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    check("t1_busy_k", 32'(busy), 32'd0);
    tick();
    check("t1_busy_k1", 32'(busy), 32'd1);
    check("t1_done_k1", 32'(done), 32'd0);
    check("t1_cnt_k1", 32'(count3), 32'd0);
    tick();
    check("t1_done_k2", 32'(done), 32'd1);
    check("t1_cnt3", 32'(count3), 32'd3);
    check("t1_acc", 32'(accepted), 32'd3);
    check("t1_ovf", 32'(overflow), 32'd0);
    bc = 2;
    dc = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dc++;
      if (!busy) break;
      bc++;
    end
    check("t1_busy_len", 32'(bc), 32'(H + 1));
    check("t1_done_cnt", 32'(dc), 32'd1);

    // Lane 5: 0+5=5, then +4 clips at 7
    commit(3'd5, 7'b0000100, 1'b0, 3'd0, 3'd0);
    check("t2_cnt5a", 32'(count5), 32'd5);
    check("t2_done", 32'(got_done), 32'd1);
    commit(3'd5, 7'b0001000, 1'b0, 3'd0, 3'd0);
    check("t2_cnt5b", 32'(count5), 32'd7);
    check("t2_acc", 32'(accepted), 32'd2);
    check("t2_ovf", 32'(overflow), 32'd1);

    // Lane 2: oversell rejected, exact sale accepted
    commit(3'd2, 7'b0100000, 1'b0, 3'd0, 3'd0);
    check("t3_cnt2a", 32'(count2), 32'd2);
    sale_valid = 1'b1;
    sale_num = 3'd2;
    sale_count = 3'd3;
    tick();
    sale_valid = 1'b0;
    check("t3_cnt2b", 32'(count2), 32'd2);
    check("t3_err1", 32'(sale_err), 32'd1);
    tick();
    check("t3_err_clr", 32'(sale_err), 32'd0);
    sale_valid = 1'b1;
    sale_count = 3'd2;
    tick();
    sale_valid = 1'b0;
    check("t3_cnt2c", 32'(count2), 32'd0);
    check("t3_err2", 32'(sale_err), 32'd0);
    sale_valid = 1'b1;
    sale_num = 3'd0;
    sale_count = 3'd1;
    tick();
    sale_valid = 1'b0;
    check("t3_err_lane0", 32'(sale_err), 32'd1);

    // Lane 4: 6, then sale 4 and restock 3 same cycle -> 5
    commit(3'd4, 7'b0000010, 1'b0, 3'd0, 3'd0);
    check("t4_cnt4a", 32'(count4), 32'd6);
    commit(3'd4, 7'b0010000, 1'b1, 3'd4, 3'd4);
    check("t4_cnt4b", 32'(count4), 32'd5);
    check("t4_acc", 32'(accepted), 32'd3);
    check("t4_ovf", 32'(overflow), 32'd0);
    // Different lanes same cycle: lane 5 sale 2, lane 6 restock 7
    commit(3'd6, 7'b0000001, 1'b1, 3'd5, 3'd2);
    check("t4_cnt5", 32'(count5), 32'd5);
    check("t4_cnt6", 32'(count6), 32'd7);
    check("t4_acc6", 32'(accepted), 32'd7);

    // Held confirm plus a re-press in HOLD: one commit of q=1
    num = 3'd1;
    addcount = 7'b0000000;
    dc = 0;
    confirm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dc++;
    end
    confirm = 1'b0;
    tick();
    if (done) dc++;
    confirm = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dc++;
    end
    confirm = 1'b0;
    tick();
    tick();
    check("t5_done_cnt", 32'(dc), 32'd1);
    check("t5_cnt1", 32'(count1), 32'd1);

    // Lane 0 commit: nothing written
    snap = all_counts();
    commit(3'd0, 7'b0100000, 1'b0, 3'd0, 3'd0);
    check("t6_counts", 32'(all_counts()), 32'(snap));
    check("t6_acc", 32'(accepted), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd1);

    // Async reset in HOLD
    num = 3'd7;
    addcount = 7'b0000001;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
    tick();
    tick();
    check("t7_busy_hold", 32'(busy), 32'd1);
    check("t7_cnt7", 32'(count7), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_counts", 32'(all_counts()), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_acc", 32'(accepted), 32'd0);
    check("t7_rst_ovf", 32'(overflow), 32'd0);
    check("t7_rst_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
